// File: rtl/mem_writeback_unit.sv
// mem_writeback_unit
//   Final memory / write-back stage. Resolves the branch condition into the
//   next PC and performs one byte/half/word load or store per cycle against a
//   unified data RAM with a low-address framebuffer (VRAM) window. A second
//   synchronous VRAM read port serves a display scanner. All outputs are
//   registered (1-cycle latency).
//
//   Byte-lane logic assumes 4-byte words, matching the addr>>2 word indexing.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   i_valid            op valid
//   i_pc, i_branch     PC of op, branch target
//   i_cond             0 Never, 1 Always, 2 Zero, 3 NotZero, 4 Carry, 5 NotCarry
//   i_zero, i_carry    ALU flags
//   i_memr, i_memw     load / store request
//   i_memt             0 B, 1 H, 2 W, 4 BU, 5 HU
//   i_addr, i_sdata    byte address (ALU result), store data
//   i_wback, i_wreg    write-back enable, destination register
//   o_valid, o_pc      registered valid, next PC
//   o_wback, o_wreg    write-back enable (0 on fault), destination register
//   o_wdata, o_fault   write-back data, misaligned/illegal access flag
//   i_vram_raddr       display read word index
//   o_vram_rdata       display read data (1-cycle latency, read-first)
module mem_writeback_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RAM_WORDS  = 4096,
  parameter int unsigned VRAM_WORDS = 128,
  parameter string       INIT_FILE  = ""
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic [XLEN-1:0]               i_pc,
  input  logic [XLEN-1:0]               i_branch,
  input  logic [2:0]                    i_cond,
  input  logic                          i_zero,
  input  logic                          i_carry,
  input  logic                          i_memr,
  input  logic                          i_memw,
  input  logic [2:0]                    i_memt,
  input  logic [XLEN-1:0]               i_addr,
  input  logic [XLEN-1:0]               i_sdata,
  input  logic                          i_wback,
  input  logic [4:0]                    i_wreg,
  output logic                          o_valid,
  output logic [XLEN-1:0]               o_pc,
  output logic                          o_wback,
  output logic [4:0]                    o_wreg,
  output logic [XLEN-1:0]               o_wdata,
  output logic                          o_fault,
  input  logic [$clog2(VRAM_WORDS)-1:0] i_vram_raddr,
  output logic [XLEN-1:0]               o_vram_rdata
);

  localparam int unsigned     RAW        = $clog2(RAM_WORDS);
  localparam int unsigned     VAW        = $clog2(VRAM_WORDS);
  localparam logic [XLEN-1:0] VRAM_BYTES = XLEN'(VRAM_WORDS * 4);

  typedef enum logic [2:0] {
    C_NEVER  = 3'd0,
    C_ALWAYS = 3'd1,
    C_ZERO   = 3'd2,
    C_NZERO  = 3'd3,
    C_CARRY  = 3'd4,
    C_NCARRY = 3'd5
  } cond_e;

  typedef enum logic [2:0] {
    MT_B  = 3'd0,
    MT_H  = 3'd1,
    MT_W  = 3'd2,
    MT_BU = 3'd4,
    MT_HU = 3'd5
  } memt_e;

  logic [XLEN-1:0] ram  [RAM_WORDS];
  logic [XLEN-1:0] vram [VRAM_WORDS];

  logic [XLEN-1:0] pc_seq, pc_next;
  logic            in_vram;
  logic [VAW-1:0]  vidx;
  logic [RAW-1:0]  ridx;
  logic [XLEN-1:0] rword, load_data, wdata_next, wr_data;
  logic [7:0]      lbyte;
  logic [15:0]     lhalf;
  logic            illegal, misalign, fault_raw, wr_en;
  logic [3:0]      be;

  always_comb begin
    pc_seq  = i_pc + XLEN'(4);
    pc_next = pc_seq;
    case (i_cond)
      C_ALWAYS: pc_next = i_branch;
      C_ZERO:   if (i_zero)   pc_next = i_branch;
      C_NZERO:  if (!i_zero)  pc_next = i_branch;
      C_CARRY:  if (i_carry)  pc_next = i_branch;
      C_NCARRY: if (!i_carry) pc_next = i_branch;
      default:  pc_next = pc_seq;
    endcase
  end

  always_comb begin
    in_vram = (i_addr < VRAM_BYTES);
    vidx    = i_addr[VAW+1:2];
    ridx    = i_addr[RAW+1:2];
    rword   = in_vram ? vram[vidx] : ram[ridx];

    illegal  = !(i_memt inside {MT_B, MT_H, MT_W, MT_BU, MT_HU});
    misalign = 1'b0;
    case (i_memt[1:0])
      2'b01:   misalign = i_addr[0];
      2'b10:   misalign = |i_addr[1:0];
      default: misalign = 1'b0;
    endcase
    // Simultaneous read+write is folded into the illegal-access fault.
    fault_raw = (i_memr | i_memw) & ((i_memr & i_memw) | illegal | misalign);

    lbyte = rword[7:0];
    case (i_addr[1:0])
      2'd0:    lbyte = rword[7:0];
      2'd1:    lbyte = rword[15:8];
      2'd2:    lbyte = rword[23:16];
      default: lbyte = rword[31:24];
    endcase
    lhalf = i_addr[1] ? rword[31:16] : rword[15:0];

    case (i_memt)
      MT_B:    load_data = {{(XLEN-8){lbyte[7]}}, lbyte};
      MT_BU:   load_data = {{(XLEN-8){1'b0}}, lbyte};
      MT_H:    load_data = {{(XLEN-16){lhalf[15]}}, lhalf};
      MT_HU:   load_data = {{(XLEN-16){1'b0}}, lhalf};
      default: load_data = rword;
    endcase

    if (fault_raw || i_memw) wdata_next = '0;
    else if (i_memr)         wdata_next = load_data;
    else                     wdata_next = i_addr;

    // Store data is replicated across lanes; the byte enables pick the lane.
    case (i_memt[1:0])
      2'b00: begin
        be      = 4'b0001 << i_addr[1:0];
        wr_data = {(XLEN/8){i_sdata[7:0]}};
      end
      2'b01: begin
        be      = i_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {(XLEN/16){i_sdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_data = i_sdata;
      end
    endcase

    wr_en = !rst && i_valid && i_memw && !i_memr && !fault_raw;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          if (in_vram) vram[vidx][8*b +: 8] <= wr_data[8*b +: 8];
          else         ram[ridx][8*b +: 8]  <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid      <= 1'b0;
      o_pc         <= '0;
      o_wback      <= 1'b0;
      o_wreg       <= '0;
      o_wdata      <= '0;
      o_fault      <= 1'b0;
      o_vram_rdata <= '0;
    end else begin
      o_valid      <= i_valid;
      o_pc         <= pc_next;
      o_wback      <= i_valid & i_wback & ~fault_raw;
      o_wreg       <= i_wreg;
      o_wdata      <= wdata_next;
      o_fault      <= i_valid & fault_raw;
      // Non-blocking read sees the pre-store word: read-first.
      o_vram_rdata <= vram[i_vram_raddr];
    end
  end

endmodule

// File: tb/tb_mem_writeback_unit.sv
module tb_mem_writeback_unit;

    localparam int XLEN       = 32;
    localparam int RAM_WORDS  = 4096;
    localparam int VRAM_WORDS = 128;

    logic        clk, rst;
    logic        i_valid, i_zero, i_carry, i_memr, i_memw, i_wback;
    logic [31:0] i_pc, i_branch, i_addr, i_sdata;
    logic [2:0]  i_cond, i_memt;
    logic [4:0]  i_wreg;
    logic [6:0]  i_vram_raddr;
    logic        o_valid, o_wback, o_fault;
    logic [31:0] o_pc, o_wdata, o_vram_rdata;
    logic [4:0]  o_wreg;

    mem_writeback_unit #(
        .XLEN(XLEN), .RAM_WORDS(RAM_WORDS), .VRAM_WORDS(VRAM_WORDS), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_pc(i_pc), .i_branch(i_branch),
        .i_cond(i_cond), .i_zero(i_zero), .i_carry(i_carry), .i_memr(i_memr),
        .i_memw(i_memw), .i_memt(i_memt), .i_addr(i_addr), .i_sdata(i_sdata),
        .i_wback(i_wback), .i_wreg(i_wreg), .o_valid(o_valid), .o_pc(o_pc),
        .o_wback(o_wback), .o_wreg(o_wreg), .o_wdata(o_wdata), .o_fault(o_fault),
        .i_vram_raddr(i_vram_raddr), .o_vram_rdata(o_vram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc, branch;
        logic [2:0]  cond;
        logic        zero, carry, memr, memw;
        logic [2:0]  memt;
        logic [31:0] addr, sdata;
        logic        wback;
        logic [4:0]  wreg;
        logic [6:0]  vraddr;
    } op_t;

    typedef struct {
        op_t         op;
        logic [31:0] e_pc, e_wdata;
        logic        e_fault, e_wback;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Byte-addressed reference memory: VRAM bytes [0,512), RAM bytes mod 16 KiB.
    logic [7:0] vmem [512];
    logic [7:0] rmem [16384];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (a < 32'd512) return vmem[a[8:0]];
        return rmem[a[13:0]];
    endfunction

    task automatic wr_byte(input logic [31:0] a, input logic [7:0] d);
        if (a < 32'd512) vmem[a[8:0]] = d;
        else             rmem[a[13:0]] = d;
    endtask

    function automatic logic [31:0] vram_word(input logic [6:0] idx);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++)
            w = w | (32'(rd_byte({23'd0, idx, 2'b00} + 32'(k))) << (8 * k));
        return w;
    endfunction

    task automatic model_op(input op_t op, output logic [31:0] e_pc, output logic [31:0] e_wdata,
                            output logic e_valid, output logic e_fault, output logic e_wback);
        int size;
        bit bad;
        logic [31:0] v;
        e_pc = op.pc + 32'd4;
        case (op.cond)
            3'd1: e_pc = op.branch;
            3'd2: if (op.zero)   e_pc = op.branch;
            3'd3: if (!op.zero)  e_pc = op.branch;
            3'd4: if (op.carry)  e_pc = op.branch;
            3'd5: if (!op.carry) e_pc = op.branch;
            default: ;
        endcase
        case (op.memt)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        bad = 0;
        if (op.memr || op.memw) begin
            if (op.memr && op.memw) bad = 1;
            else if (size == 0) bad = 1;
            else if ((op.addr % 32'(size)) != 0) bad = 1;
        end
        e_valid = op.valid;
        e_fault = op.valid && bad;
        e_wback = op.valid && op.wback && !bad;
        if (bad) e_wdata = '0;
        else if (op.memw) begin
            e_wdata = '0;
            if (op.valid)
                for (int k = 0; k < size; k++) wr_byte(op.addr + 32'(k), 8'(op.sdata >> (8 * k)));
        end else if (op.memr) begin
            v = '0;
            for (int k = 0; k < size; k++) v = v | (32'(rd_byte(op.addr + 32'(k))) << (8 * k));
            if (op.memt < 3'd4 && v[8*size-1] && size < 4) v = v | (32'hFFFF_FFFF << (8 * size));
            e_wdata = v;
        end else e_wdata = op.addr;
    endtask

    function automatic op_t mk(input logic valid, input logic [2:0] cond, input logic zero,
                               input logic carry, input logic memr, input logic memw,
                               input logic [2:0] memt, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic wback, input logic [4:0] wreg);
        op_t o;
        o.valid = valid; o.pc = 32'h100; o.branch = 32'h200; o.cond = cond;
        o.zero = zero; o.carry = carry; o.memr = memr; o.memw = memw; o.memt = memt;
        o.addr = addr; o.sdata = sdata; o.wback = wback; o.wreg = wreg; o.vraddr = 7'd0;
        return o;
    endfunction

    task automatic drive(input op_t op);
        i_valid = op.valid; i_pc = op.pc; i_branch = op.branch; i_cond = op.cond;
        i_zero = op.zero; i_carry = op.carry; i_memr = op.memr; i_memw = op.memw;
        i_memt = op.memt; i_addr = op.addr; i_sdata = op.sdata; i_wback = op.wback;
        i_wreg = op.wreg; i_vram_raddr = op.vraddr;
    endtask

    // Apply one op for one cycle and compare every output against the model.
    task automatic apply(input op_t op, input bit chk_disp);
        logic [31:0] e_pc, e_wdata, e_disp;
        logic e_valid, e_fault, e_wback;
        drive(op);
        e_disp = vram_word(op.vraddr);
        model_op(op, e_pc, e_wdata, e_valid, e_fault, e_wback);
        @(posedge clk);
        #1;
        check("o_valid", 32'(o_valid), 32'(e_valid));
        check("o_fault", 32'(o_fault), 32'(e_fault));
        check("o_wback", 32'(o_wback), 32'(e_wback));
        check("o_pc", o_pc, e_pc);
        check("o_wreg", 32'(o_wreg), 32'(op.wreg));
        if (e_valid) check("o_wdata", o_wdata, e_wdata);
        if (chk_disp) check("o_vram_rdata", o_vram_rdata, e_disp);
    endtask

    vec_t tbl[$];

    initial begin
        op_t  op;
        logic [31:0] old;

        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_valid", 32'(o_valid), 0);
        check("rst_o_pc", o_pc, 0);
        check("rst_o_wback", 32'(o_wback), 0);
        check("rst_o_wreg", 32'(o_wreg), 0);
        check("rst_o_wdata", o_wdata, 0);
        check("rst_o_fault", 32'(o_fault), 0);
        check("rst_o_vram_rdata", o_vram_rdata, 0);
        rst = 1'b0;

        // Give every word the random stimulus can touch a known value.
        for (int w = 0; w < 128; w++)
            apply(mk(1, 0, 0, 0, 0, 1, 3'd2, 32'(w * 4), $urandom, 0, 0), 0);
        for (int w = 0; w < 64; w++)
            apply(mk(1, 0, 0, 0, 0, 1, 3'd2, 32'h800 + 32'(w * 4), $urandom, 0, 0), 0);

        //              valid cond z c  r  w  memt  addr          sdata          wb wreg      e_pc     e_wdata       f  wb
        tbl.push_back('{mk(1, 2, 1, 0, 0, 0, 3'd0, 32'h1234, 0, 1, 5),          32'h200, 32'h0000_1234, 0, 1});
        tbl.push_back('{mk(1, 2, 0, 0, 0, 0, 3'd0, 32'h0, 0, 0, 1),             32'h104, 32'h0,         0, 0});
        tbl.push_back('{mk(1, 7, 1, 1, 0, 0, 3'd0, 32'h8, 0, 0, 1),             32'h104, 32'h8,         0, 0});
        tbl.push_back('{mk(1, 4, 0, 1, 0, 0, 3'd0, 32'h8, 0, 0, 1),             32'h200, 32'h8,         0, 0});
        tbl.push_back('{mk(1, 5, 0, 1, 0, 0, 3'd0, 32'h8, 0, 0, 1),             32'h104, 32'h8,         0, 0});
        tbl.push_back('{mk(1, 1, 0, 0, 0, 0, 3'd0, 32'h8, 0, 0, 1),             32'h200, 32'h8,         0, 0});
        tbl.push_back('{mk(1, 0, 1, 1, 0, 0, 3'd0, 32'h8, 0, 0, 1),             32'h104, 32'h8,         0, 0});
        tbl.push_back('{mk(1, 3, 0, 0, 0, 0, 3'd0, 32'h8, 0, 0, 1),             32'h200, 32'h8,         0, 0});
        tbl.push_back('{mk(1, 0, 0, 0, 0, 1, 3'd2, 32'h800, 32'h11223344, 0, 0), 32'h104, 32'h0,        0, 0});
        tbl.push_back('{mk(1, 0, 0, 0, 0, 1, 3'd0, 32'h801, 32'hFFFFFFAA, 0, 0), 32'h104, 32'h0,        0, 0});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd2, 32'h800, 0, 1, 3),           32'h104, 32'h1122AA44,  0, 1});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd0, 32'h801, 0, 1, 3),           32'h104, 32'hFFFFFFAA,  0, 1});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd4, 32'h801, 0, 1, 3),           32'h104, 32'h000000AA,  0, 1});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd5, 32'h802, 0, 1, 3),           32'h104, 32'h00001122,  0, 1});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd1, 32'h802, 0, 1, 3),           32'h104, 32'h00001122,  0, 1});
        tbl.push_back('{mk(1, 0, 0, 0, 0, 1, 3'd1, 32'h803, 32'hBEEF, 1, 3),    32'h104, 32'h0,         1, 0});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd2, 32'h802, 0, 1, 3),           32'h104, 32'h0,         1, 0});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd2, 32'h800, 0, 1, 3),           32'h104, 32'h1122AA44,  0, 1});
        tbl.push_back('{mk(1, 0, 0, 0, 0, 1, 3'd1, 32'h802, 32'h12348001, 0, 0), 32'h104, 32'h0,        0, 0});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd1, 32'h802, 0, 1, 3),           32'h104, 32'hFFFF8001,  0, 1});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd2, 32'h800, 0, 1, 3),           32'h104, 32'h8001AA44,  0, 1});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd3, 32'h800, 0, 1, 3),           32'h104, 32'h0,         1, 0});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 1, 3'd2, 32'h800, 0, 1, 3),           32'h104, 32'h0,         1, 0});
        tbl.push_back('{mk(0, 0, 0, 0, 1, 0, 3'd2, 32'h800, 0, 1, 3),           32'h104, 32'h0,         0, 0});
        tbl.push_back('{mk(0, 0, 0, 0, 0, 1, 3'd2, 32'h800, 32'h0, 1, 3),       32'h104, 32'h0,         0, 0});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd2, 32'h800, 0, 1, 3),           32'h104, 32'h8001AA44,  0, 1});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd0, 32'h800, 0, 1, 3),           32'h104, 32'h00000044,  0, 1});
        tbl.push_back('{mk(1, 0, 0, 0, 1, 0, 3'd0, 32'h803, 0, 1, 3),           32'h104, 32'hFFFFFF80,  0, 1});

        foreach (tbl[i]) begin
            apply(tbl[i].op, 1);
            check($sformatf("tbl%0d_pc", i), o_pc, tbl[i].e_pc);
            check($sformatf("tbl%0d_fault", i), 32'(o_fault), 32'(tbl[i].e_fault));
            check($sformatf("tbl%0d_wback", i), 32'(o_wback), 32'(tbl[i].e_wback));
            if (tbl[i].op.valid) check($sformatf("tbl%0d_wdata", i), o_wdata, tbl[i].e_wdata);
        end

        // Display port is read-first against a same-cycle CPU store.
        old = vram_word(7'd4);
        op = mk(1, 0, 0, 0, 0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0);
        op.vraddr = 7'd4;
        apply(op, 1);
        check("disp_old", o_vram_rdata, old);
        op = mk(1, 0, 0, 0, 0, 0, 3'd0, 32'h0, 0, 0, 0);
        op.vraddr = 7'd4;
        apply(op, 1);
        check("disp_new", o_vram_rdata, 32'hDEADBEEF);
        apply(mk(1, 0, 0, 0, 1, 0, 3'd2, 32'h10, 0, 1, 7), 1);
        check("lw_vram", o_wdata, 32'hDEADBEEF);

        // Store pending during reset must not reach memory.
        apply(mk(1, 0, 0, 0, 0, 1, 3'd2, 32'h900, 32'h5A5A1234, 0, 0), 1);
        apply(mk(1, 1, 0, 0, 0, 0, 3'd0, 32'h77, 0, 1, 9), 1);
        drive(mk(1, 1, 0, 0, 0, 1, 3'd2, 32'h900, 32'hFFFFFFFF, 1, 9));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_o_valid", 32'(o_valid), 0);
        check("mid_rst_o_pc", o_pc, 0);
        check("mid_rst_o_wback", 32'(o_wback), 0);
        check("mid_rst_o_wreg", 32'(o_wreg), 0);
        check("mid_rst_o_wdata", o_wdata, 0);
        check("mid_rst_o_fault", 32'(o_fault), 0);
        check("mid_rst_o_vram_rdata", o_vram_rdata, 0);
        apply(mk(1, 0, 0, 0, 1, 0, 3'd2, 32'h900, 0, 1, 4), 1);
        check("lw_after_rst", o_wdata, 32'h5A5A1234);

        // Randomized ops against the reference model.
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            op.valid  = ($urandom_range(0, 9) != 0);
            op.pc     = $urandom;
            op.branch = $urandom;
            op.cond   = 3'($urandom_range(0, 7));
            op.zero   = 1'($urandom);
            op.carry  = 1'($urandom);
            r = $urandom_range(0, 3);
            op.memr   = (r == 1) || (r == 3 && $urandom_range(0, 3) == 0);
            op.memw   = (r == 2) || (r == 3 && op.memr);
            op.memt   = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       op.addr = 32'($urandom_range(0, 511));
                1:       op.addr = 32'h800 + 32'($urandom_range(0, 255));
                default: op.addr = 32'h4800 + 32'($urandom_range(0, 255));
            endcase
            if (!op.memr && !op.memw) op.addr = $urandom;
            op.sdata  = $urandom;
            op.wback  = 1'($urandom);
            op.wreg   = 5'($urandom);
            op.vraddr = 7'($urandom);
            apply(op, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
